// File: rtl/conv_accel_pkg.sv
// Shared definitions for the convolution accelerator input path.
// Holds the info-FIFO entry field layout, the write-controller FSM state
// encoding and the default datapath sizes.
package conv_accel_pkg;

  // Info FIFO entry layout: [31:16] buffer index, [15:0] buffer address.
  localparam int INFO_IDX_LSB = 16;
  localparam int INFO_ADR_LSB = 0;
  localparam int INFO_FIELD_W = 16;

  localparam int WORD_W_DEF      = 512;
  localparam int BUFFERS_NUM_DEF = 3;

  // Write-controller FSM encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

endpackage

// File: rtl/conv_input_buf_wr_ctrl_if.sv
// Bus bundle between the DDR read path, the load-info FIFO and the input
// row buffers.
//   master : environment side (drives DDR beats and FIFO read data)
//   slave  : write controller side (pops the FIFO, writes the row buffers)
interface conv_input_buf_wr_ctrl_if #(
  parameter int WORD_W    = 512,
  parameter int INFO_W    = 32,
  parameter int BUF_ADR_W = 12,
  parameter int BUF_IDX_W = 2
);
  logic                 ddr_rd_data_valid;
  logic [WORD_W-1:0]    ddr_rd_data;
  logic                 load_input_info_fifo_empty;
  logic [INFO_W-1:0]    input_word_load_info_fifo_rd;
  logic                 input_word_load_info_fifo_en_rd;
  logic                 input_word_buf_en_wr;
  logic [BUF_IDX_W-1:0] input_word_buf_idx_wr;
  logic [BUF_ADR_W-1:0] input_word_buf_adr_wr;
  logic [WORD_W-1:0]    input_word_buf_wr;

  modport slave (
    input  ddr_rd_data_valid, ddr_rd_data,
    input  load_input_info_fifo_empty, input_word_load_info_fifo_rd,
    output input_word_load_info_fifo_en_rd,
    output input_word_buf_en_wr, input_word_buf_idx_wr,
    output input_word_buf_adr_wr, input_word_buf_wr
  );

  modport master (
    output ddr_rd_data_valid, ddr_rd_data,
    output load_input_info_fifo_empty, input_word_load_info_fifo_rd,
    input  input_word_load_info_fifo_en_rd,
    input  input_word_buf_en_wr, input_word_buf_idx_wr,
    input  input_word_buf_adr_wr, input_word_buf_wr
  );
endinterface

// File: rtl/conv_input_info_decode.sv
// Splits a load-info FIFO entry into buffer index and address and flags
// entries that cannot be written (index out of range or address beyond the
// row buffer depth).
//   info : raw FIFO entry
//   idx  : buffer index, truncated to output width
//   adr  : buffer address, truncated to output width
//   bad  : entry is out of range
module conv_input_info_decode
  import conv_accel_pkg::*;
#(
  parameter int BUFFERS_NUM = BUFFERS_NUM_DEF,
  parameter int INFO_W      = 32,
  parameter int BUF_ADR_W   = 12,
  parameter int BUF_IDX_W   = 2
) (
  input  logic [INFO_W-1:0]    info,
  output logic [BUF_IDX_W-1:0] idx,
  output logic [BUF_ADR_W-1:0] adr,
  output logic                 bad
);
  logic [INFO_FIELD_W-1:0] idx_f, adr_f;

  assign idx_f = info[INFO_IDX_LSB +: INFO_FIELD_W];
  assign adr_f = info[INFO_ADR_LSB +: INFO_FIELD_W];
  assign idx   = idx_f[BUF_IDX_W-1:0];
  assign adr   = adr_f[BUF_ADR_W-1:0];
  // The full 16-bit fields are checked so truncation never aliases a bad
  // entry onto a legal buffer location.
  assign bad   = (idx_f >= INFO_FIELD_W'(BUFFERS_NUM)) ||
                 ((adr_f >> BUF_ADR_W) != '0);
endmodule

// File: rtl/conv_input_buf_wr_ctrl.sv
// Input row-buffer write controller. Each accepted DDR beat pops one entry
// from the load-info FIFO; the beat is registered and written one cycle later
// to the buffer/address carried by the FIFO read data. Counts beats against
// the latched total, pulses fin when the last write has gone out, and keeps
// sticky protocol error flags.
//   clk, reset          : clock, async active-low reset
//   conv_load_input     : start pulse (IDLE only)
//   expected_word_num   : beats in this load, latched at start
//   bus                 : DDR beat in, FIFO pop/data, buffer write out
//   words_written       : beats written (incl. suppressed), saturating
//   busy                : RUN or FLUSH
//   conv_load_input_buf_fin : one-cycle done pulse
//   err_underflow / err_info / err_stray : sticky errors, cleared on start
module conv_input_buf_wr_ctrl
  import conv_accel_pkg::*;
#(
  parameter int BUFFERS_NUM = BUFFERS_NUM_DEF,
  parameter int WORD_W      = WORD_W_DEF,
  parameter int INFO_W      = 32,
  parameter int BUF_ADR_W   = 12,
  parameter int BUF_IDX_W   = 2,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 conv_load_input,
  input  logic [CNT_W-1:0]     expected_word_num,
  conv_input_buf_wr_ctrl_if.slave bus,
  output logic [CNT_W-1:0]     words_written,
  output logic                 busy,
  output logic                 conv_load_input_buf_fin,
  output logic                 err_underflow,
  output logic                 err_info,
  output logic                 err_stray
);
  logic [1:0]           state;
  logic [CNT_W-1:0]     exp_q, acc_cnt;
  logic                 pend;
  logic [WORD_W-1:0]    data_q;

  logic                 start, start_run, run_eff, accept, last;
  logic                 underflow, stray, wr_fire;
  logic [CNT_W-1:0]     exp_eff, acc_base;
  logic [BUF_IDX_W-1:0] dec_idx;
  logic [BUF_ADR_W-1:0] dec_adr;
  logic                 dec_bad;

  conv_input_info_decode #(
    .BUFFERS_NUM(BUFFERS_NUM), .INFO_W(INFO_W),
    .BUF_ADR_W(BUF_ADR_W), .BUF_IDX_W(BUF_IDX_W)
  ) u_dec (
    .info(bus.input_word_load_info_fifo_rd),
    .idx (dec_idx),
    .adr (dec_adr),
    .bad (dec_bad)
  );

  // A start with a beat in the same cycle treats the beat as a RUN beat, so
  // the accept path looks through to the incoming count on the start cycle.
  assign start     = (state == ST_IDLE) && conv_load_input;
  assign start_run = start && (expected_word_num != '0);
  assign run_eff   = (state == ST_RUN) || start_run;
  assign exp_eff   = start ? expected_word_num : exp_q;
  assign acc_base  = start ? '0 : acc_cnt;

  assign accept    = run_eff && bus.ddr_rd_data_valid && !bus.load_input_info_fifo_empty;
  assign underflow = run_eff && bus.ddr_rd_data_valid &&  bus.load_input_info_fifo_empty;
  assign stray     = bus.ddr_rd_data_valid && !run_eff;
  assign last      = accept && ((acc_base + CNT_W'(1)) == exp_eff);

  // FIFO dout is valid the cycle after the pop, which is when pend is high.
  assign wr_fire   = pend && !dec_bad;

  assign bus.input_word_load_info_fifo_en_rd = accept;
  assign bus.input_word_buf_en_wr  = wr_fire;
  assign bus.input_word_buf_idx_wr = wr_fire ? dec_idx : '0;
  assign bus.input_word_buf_adr_wr = wr_fire ? dec_adr : '0;
  assign bus.input_word_buf_wr     = wr_fire ? data_q  : '0;

  assign busy = (state != ST_IDLE);
  // FLUSH with nothing pending: either the cycle after the final write or
  // the cycle after a zero-length start.
  assign conv_load_input_buf_fin = (state == ST_FLUSH) && !pend;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      exp_q         <= '0;
      acc_cnt       <= '0;
      pend          <= 1'b0;
      data_q        <= '0;
      words_written <= '0;
      err_underflow <= 1'b0;
      err_info      <= 1'b0;
      err_stray     <= 1'b0;
    end else begin
      pend <= accept;
      if (accept) data_q <= bus.ddr_rd_data;

      if (start)
        words_written <= '0;
      else if (pend && (words_written != '1))
        words_written <= words_written + CNT_W'(1);

      // Clear on start, but an error raised in the start cycle still sticks.
      err_underflow <= (err_underflow && !start) || underflow;
      err_info      <= (err_info      && !start) || (pend && dec_bad);
      err_stray     <= (err_stray     && !start) || stray;

      if (accept)     acc_cnt <= acc_base + CNT_W'(1);
      else if (start) acc_cnt <= '0;

      case (state)
        ST_IDLE: if (conv_load_input) begin
          exp_q <= expected_word_num;
          state <= (!start_run || last) ? ST_FLUSH : ST_RUN;
        end
        ST_RUN:   if (last)  state <= ST_FLUSH;
        ST_FLUSH: if (!pend) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_input_buf_wr_ctrl.sv
module tb_conv_input_buf_wr_ctrl;
  import conv_accel_pkg::*;

  localparam int WORD_W = 512, INFO_W = 32, BUF_ADR_W = 12, BUF_IDX_W = 2;
  localparam int CNT_W = 16, BUFFERS_NUM = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic conv_load_input = 1'b0;
  logic [CNT_W-1:0] expected_word_num = '0;
  logic [CNT_W-1:0] words_written;
  logic busy, fin, err_underflow, err_info, err_stray;

  conv_input_buf_wr_ctrl_if #(.WORD_W(WORD_W), .INFO_W(INFO_W),
    .BUF_ADR_W(BUF_ADR_W), .BUF_IDX_W(BUF_IDX_W)) bus();

  conv_input_buf_wr_ctrl #(.BUFFERS_NUM(BUFFERS_NUM), .WORD_W(WORD_W), .INFO_W(INFO_W),
    .BUF_ADR_W(BUF_ADR_W), .BUF_IDX_W(BUF_IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .conv_load_input(conv_load_input),
    .expected_word_num(expected_word_num), .bus(bus),
    .words_written(words_written), .busy(busy),
    .conv_load_input_buf_fin(fin), .err_underflow(err_underflow),
    .err_info(err_info), .err_stray(err_stray));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Info FIFO environment: standard FIFO, dout valid the cycle after a pop.
  logic [INFO_W-1:0] fq[$];
  always @(posedge clk) begin
    if (bus.input_word_load_info_fifo_en_rd && fq.size() > 0)
      bus.input_word_load_info_fifo_rd <= fq.pop_front();
    bus.load_input_info_fifo_empty <= (fq.size() == 0);
  end

  // Monitor.
  typedef struct {
    int cyc;
    logic [BUF_IDX_W-1:0] idx;
    logic [BUF_ADR_W-1:0] adr;
    logic [WORD_W-1:0] data;
  } wr_t;
  wr_t wq[$];
  int pop_cyc[$], fin_cyc[$];
  int gate_bad = 0;
  always @(negedge clk) begin
    if (bus.input_word_buf_en_wr)
      wq.push_back('{cyc, bus.input_word_buf_idx_wr, bus.input_word_buf_adr_wr, bus.input_word_buf_wr});
    else if (bus.input_word_buf_idx_wr != 0 || bus.input_word_buf_adr_wr != 0 || bus.input_word_buf_wr != 0)
      gate_bad++;
    if (bus.input_word_load_info_fifo_en_rd) pop_cyc.push_back(cyc);
    if (fin) fin_cyc.push_back(cyc);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr_mon();
    wq.delete(); pop_cyc.delete(); fin_cyc.delete();
  endtask

  task automatic beat(input bit v, input logic [WORD_W-1:0] d);
    bus.ddr_rd_data_valid = v;
    bus.ddr_rd_data = v ? d : '0;
  endtask

  task automatic start(input int n, output int s);
    s = cyc;
    conv_load_input = 1'b1;
    expected_word_num = CNT_W'(n);
    tick();
    conv_load_input = 1'b0;
  endtask

  function automatic logic [WORD_W-1:0] pat(input int v);
    return {16{v}};
  endfunction

  function automatic logic [INFO_W-1:0] ent(input int idx, input int adr);
    return {idx[15:0], adr[15:0]};
  endfunction

  // Single-beat vectors: FIFO entry in, write-port response out.
  typedef struct {
    logic [INFO_W-1:0] info;
    int d;
    bit en;
    logic [BUF_IDX_W-1:0] idx;
    logic [BUF_ADR_W-1:0] adr;
    bit bad;
  } vec_t;
  vec_t tbl[8];

  // Random-phase reference model state.
  logic [INFO_W-1:0] mq[$];
  int lvl;

  task automatic push_entry();
    logic [INFO_W-1:0] e;
    int r;
    r = $urandom_range(0, 9);
    if (r == 0)      e = ent(3 + $urandom_range(0, 5), $urandom_range(0, 4095));
    else if (r == 1) e = ent($urandom_range(0, 2), 4096 + $urandom_range(0, 60000));
    else             e = ent($urandom_range(0, 2), $urandom_range(0, 4095));
    fq.push_back(e);
    mq.push_back(e);
    lvl++;
  endtask

  initial begin
    int s, first, n, extra, m_acc;
    bit m_uf, m_info, m_stray, active, v, ok;
    int acc[$];
    wr_t ew[$];
    logic [WORD_W-1:0] d;
    logic [INFO_W-1:0] e;
    int exp_idx[4] = '{0, 1, 2, 0};
    int exp_adr[4] = '{0, 0, 0, 1};

    tbl[0] = '{32'h0000_0000, 11, 1'b1, 2'd0, 12'h000, 1'b0};
    tbl[1] = '{32'h0001_0123, 12, 1'b1, 2'd1, 12'h123, 1'b0};
    tbl[2] = '{32'h0002_0FFF, 13, 1'b1, 2'd2, 12'hFFF, 1'b0};
    tbl[3] = '{32'h0003_0000, 14, 1'b0, 2'd0, 12'h000, 1'b1};
    tbl[4] = '{32'h0000_1000, 15, 1'b0, 2'd0, 12'h000, 1'b1};
    tbl[5] = '{32'h0002_8000, 16, 1'b0, 2'd0, 12'h000, 1'b1};
    tbl[6] = '{32'hFFFF_0001, 17, 1'b0, 2'd0, 12'h000, 1'b1};
    tbl[7] = '{32'h0001_0ABC, 18, 1'b1, 2'd1, 12'hABC, 1'b0};

    beat(0, '0);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_words", words_written, 0);
    chk("rst_en_wr", bus.input_word_buf_en_wr, 0);
    chk("rst_en_rd", bus.input_word_load_info_fifo_en_rd, 0);
    chk("rst_errs", {err_underflow, err_info, err_stray, fin}, 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Basic load: valid toggling, four entries.
    fq.delete();
    fq.push_back(ent(0, 0)); fq.push_back(ent(1, 0));
    fq.push_back(ent(2, 0)); fq.push_back(ent(0, 1));
    tick(); clr_mon(); acc.delete();
    start(4, s);
    for (int i = 0; i < 8; i++) begin
      v = (i % 2 == 0);
      if (v) acc.push_back(cyc);
      beat(v, pat(i / 2 + 1));
      tick();
    end
    beat(0, '0);
    repeat (4) tick();
    chk("basic_nwr", wq.size(), 4);
    for (int i = 0; i < 4 && i < wq.size(); i++) begin
      chk("basic_lat", wq[i].cyc, acc[i] + 1);
      chk("basic_idx", wq[i].idx, exp_idx[i]);
      chk("basic_adr", wq[i].adr, exp_adr[i]);
      chk("basic_data", wq[i].data == pat(i + 1), 1);
    end
    chk("basic_nfin", fin_cyc.size(), 1);
    if (fin_cyc.size() > 0) chk("basic_fin_cyc", fin_cyc[0], acc[3] + 2);
    chk("basic_words", words_written, 4);
    chk("basic_pops", pop_cyc.size(), 4);

    // Back-to-back: eight beats with valid held high.
    fq.delete();
    for (int i = 0; i < 8; i++) fq.push_back(ent(i % 3, i));
    tick(); clr_mon();
    start(8, s);
    first = cyc;
    for (int i = 0; i < 8; i++) begin
      beat(1, pat(100 + i));
      tick();
    end
    beat(0, '0);
    repeat (4) tick();
    chk("b2b_nwr", wq.size(), 8);
    ok = (wq.size() == 8);
    for (int i = 0; i < 8 && i < wq.size(); i++)
      if (wq[i].cyc != first + 1 + i || wq[i].data != pat(100 + i) ||
          wq[i].idx != BUF_IDX_W'(i % 3) || wq[i].adr != BUF_ADR_W'(i)) ok = 0;
    chk("b2b_stream", ok, 1);
    chk("b2b_pops", pop_cyc.size(), 8);
    chk("b2b_nfin", fin_cyc.size(), 1);
    if (fin_cyc.size() > 0) chk("b2b_fin_cyc", fin_cyc[0], first + 9);

    // Underflow: first beat finds the FIFO empty.
    fq.delete();
    tick(); clr_mon();
    start(2, s);
    beat(1, pat(7));
    fq.push_back(ent(1, 3)); fq.push_back(ent(2, 4));
    tick();
    beat(1, pat(8)); tick();
    beat(1, pat(9)); tick();
    beat(0, '0);
    repeat (4) tick();
    chk("uf_err", err_underflow, 1);
    chk("uf_nwr", wq.size(), 2);
    if (wq.size() > 0) chk("uf_data0", wq[0].data == pat(8), 1);
    chk("uf_pops", pop_cyc.size(), 2);
    chk("uf_words", words_written, 2);
    chk("uf_nfin", fin_cyc.size(), 1);

    // Bad info entries: counted, never written.
    fq.delete();
    fq.push_back(ent(3, 0)); fq.push_back(ent(0, 16'h1000));
    tick(); clr_mon();
    start(2, s);
    beat(1, pat(21)); tick();
    beat(1, pat(22)); tick();
    beat(0, '0);
    repeat (4) tick();
    chk("bad_nwr", wq.size(), 0);
    chk("bad_err", err_info, 1);
    chk("bad_words", words_written, 2);
    chk("bad_nfin", fin_cyc.size(), 1);

    // Zero length start, then a stray beat in IDLE.
    fq.delete();
    fq.push_back(ent(0, 5));
    tick(); clr_mon();
    start(0, s);
    repeat (3) tick();
    chk("zero_nfin", fin_cyc.size(), 1);
    if (fin_cyc.size() > 0) chk("zero_fin_cyc", fin_cyc[0], s + 1);
    chk("zero_pops", pop_cyc.size(), 0);
    chk("zero_stray_clr", err_stray, 0);
    beat(1, pat(3)); tick();
    beat(0, '0);
    repeat (2) tick();
    chk("stray_err", err_stray, 1);
    chk("stray_nwr", wq.size(), 0);
    chk("stray_pops", pop_cyc.size(), 0);
    chk("stray_busy", busy, 0);

    // Table of single-beat loads.
    for (int t = 0; t < 8; t++) begin
      fq.delete();
      fq.push_back(tbl[t].info);
      tick(); clr_mon();
      start(1, s);
      beat(1, pat(tbl[t].d)); tick();
      beat(0, '0);
      @(negedge clk);
      chk($sformatf("tbl%0d_en", t), bus.input_word_buf_en_wr, tbl[t].en);
      chk($sformatf("tbl%0d_idx", t), bus.input_word_buf_idx_wr, tbl[t].idx);
      chk($sformatf("tbl%0d_adr", t), bus.input_word_buf_adr_wr, tbl[t].adr);
      chk($sformatf("tbl%0d_data", t),
          bus.input_word_buf_wr == (tbl[t].en ? pat(tbl[t].d) : '0), 1);
      tick(); tick();
      chk($sformatf("tbl%0d_err", t), err_info, tbl[t].bad);
      chk($sformatf("tbl%0d_words", t), words_written, 1);
      chk($sformatf("tbl%0d_nfin", t), fin_cyc.size(), 1);
    end

    // Reset with a write pending.
    fq.delete();
    fq.push_back(ent(1, 7)); fq.push_back(ent(2, 9));
    tick(); clr_mon();
    start(2, s);
    beat(1, pat(55)); tick();
    reset = 1'b0;
    beat(0, '0);
    #1;
    chk("rstmid_en_wr", bus.input_word_buf_en_wr, 0);
    chk("rstmid_bus", {bus.input_word_buf_idx_wr, bus.input_word_buf_adr_wr}, 0);
    chk("rstmid_data", bus.input_word_buf_wr == '0, 1);
    chk("rstmid_outs", {words_written, busy, fin, err_underflow, err_info, err_stray}, 0);
    tick(); tick();
    reset = 1'b1;
    tick(); tick();
    chk("rstmid_nwr", wq.size(), 0);
    chk("rstmid_nfin", fin_cyc.size(), 0);
    fq.delete();
    fq.push_back(ent(2, 12'h0AB));
    tick(); clr_mon();
    start(1, s);
    beat(1, pat(66)); tick();
    beat(0, '0);
    repeat (3) tick();
    chk("fresh_nwr", wq.size(), 1);
    if (wq.size() > 0) begin
      chk("fresh_idx", wq[0].idx, 2);
      chk("fresh_adr", wq[0].adr, 12'h0AB);
      chk("fresh_data", wq[0].data == pat(66), 1);
    end
    chk("fresh_words", words_written, 1);
    chk("fresh_nfin", fin_cyc.size(), 1);
    chk("fresh_errs", {err_underflow, err_info, err_stray}, 0);

    // Randomized loads against a transaction-level model: a beat is taken
    // while the load is open and the FIFO model holds an entry; entries are
    // consumed in order and written only if in range.
    fq.delete(); mq.delete(); lvl = 0;
    tick();
    for (int ld = 0; ld < 8; ld++) begin
      n = $urandom_range(1, 12);
      clr_mon(); ew.delete();
      m_acc = 0; m_uf = 0; m_info = 0; m_stray = 0;
      conv_load_input = 1'b1;
      expected_word_num = CNT_W'(n);
      repeat ($urandom_range(0, 3)) push_entry();
      tick();
      conv_load_input = 1'b0;
      active = 1; extra = 0;
      for (int k = 0; k < 300; k++) begin
        v = (k > 40) ? 1'b1 : 1'($urandom_range(0, 1));
        d = {16{$urandom}};
        if (v) begin
          if (active && lvl > 0) begin
            e = mq.pop_front(); lvl--; m_acc++;
            if (e[31:16] < BUFFERS_NUM && e[15:0] < 4096)
              ew.push_back('{cyc + 1, BUF_IDX_W'(e[31:16]), BUF_ADR_W'(e[15:0]), d});
            else m_info = 1;
            if (m_acc == n) active = 0;
          end else if (active) m_uf = 1;
          else m_stray = 1;
        end
        if (k > 40 || $urandom_range(0, 2) == 0) push_entry();
        beat(v, d);
        tick();
        if (!active) begin
          extra++;
          if (extra > 3) break;
        end
      end
      beat(0, '0);
      repeat (3) tick();
      chk("rnd_closed", active, 0);
      chk("rnd_nwr", wq.size(), ew.size());
      ok = (wq.size() == ew.size());
      for (int i = 0; i < ew.size() && i < wq.size(); i++)
        if (wq[i].cyc != ew[i].cyc || wq[i].idx != ew[i].idx ||
            wq[i].adr != ew[i].adr || wq[i].data != ew[i].data) ok = 0;
      chk("rnd_writes", ok, 1);
      chk("rnd_pops", pop_cyc.size(), m_acc);
      chk("rnd_words", words_written, n);
      chk("rnd_uf", err_underflow, m_uf);
      chk("rnd_info", err_info, m_info);
      chk("rnd_stray", err_stray, m_stray);
      chk("rnd_nfin", fin_cyc.size(), 1);
    end

    chk("gate_zero", gate_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/conv_input_buf_wr_ctrl.md
Name: conv_input_buf_wr_ctrl

Overview:
- Downstream stage of conv_load_input_ddr_controller.
- Consumes 512-bit DDR read beats for the input feature map; for each beat, pops one entry from load_input_info_fifo, which gives the target row buffer and address.
- Writes the beat into one of BUFFERS_NUM input row buffers one cycle later.
- Counts beats against the expected word total for the load, raises a done pulse, and flags protocol errors.

Parameters:
- BUFFERS_NUM, 3, number of input row buffers.
- WORD_W, 512, DDR/buffer word width.
- INFO_W, 32, info FIFO entry width: [31:16] buffer index, [15:0] buffer address.
- BUF_ADR_W, 12, row buffer address width (4096 words).
- BUF_IDX_W, 2, buffer index output width.
- CNT_W, 16, word counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- conv_load_input  in  1  start pulse; sampled in IDLE only.
- expected_word_num  in  CNT_W  total beats for this load; latched on start.
- ddr_rd_data_valid  in  1  DDR read beat valid.
- ddr_rd_data  in  WORD_W  DDR read beat.
- load_input_info_fifo_empty  in  1  info FIFO empty.
- input_word_load_info_fifo_rd  in  INFO_W  FIFO dout; standard FIFO, valid 1 cycle after rd_en.
- input_word_load_info_fifo_en_rd  out  1  FIFO pop.
- input_word_buf_en_wr  out  1  buffer write enable.
- input_word_buf_idx_wr  out  BUF_IDX_W  target buffer.
- input_word_buf_adr_wr  out  BUF_ADR_W  target address.
- input_word_buf_wr  out  WORD_W  write data.
- words_written  out  CNT_W  beats written in the current load.
- busy  out  1  high in RUN/FLUSH.
- conv_load_input_buf_fin  out  1  one-cycle done pulse.
- err_underflow  out  1  sticky: beat arrived with FIFO empty.
- err_info  out  1  sticky: index >= BUFFERS_NUM, or address bits [15:BUF_ADR_W] nonzero.
- err_stray  out  1  sticky: beat arrived in IDLE.

Behaviour:
Reset:
- All outputs 0, FSM = IDLE, counters 0, sticky errors cleared.
- Reset mid-load aborts the load; no write follows.

FSM: IDLE -> RUN -> FLUSH -> IDLE.
- IDLE:
  - conv_load_input=1 latches expected_word_num, clears words_written and all sticky errors.
  - If the latched count is 0, go straight to FLUSH.
  - Beats arriving in IDLE: no pop, no write, set err_stray.
- RUN: a beat is accepted when ddr_rd_data_valid=1 and the FIFO is not empty.
  - input_word_load_info_fifo_en_rd = RUN & ddr_rd_data_valid & !load_input_info_fifo_empty (combinational).
  - Cycle N (accept): register ddr_rd_data; set a pending flag.
  - Cycle N+1: en_wr=1; data = registered beat; idx/adr taken from FIFO dout. Write latency is exactly 1 cycle.
  - Bad index or address: set err_info, suppress en_wr, still count the beat.
  - Back-to-back beats sustain 1 write/cycle.
  - Beat with FIFO empty: dropped, not counted, err_underflow set.
  - Accepted-beat counter reaching the latched count moves the FSM to FLUSH; further beats are treated as IDLE beats (err_stray).
- FLUSH:
  - Waits for the last pending write.
  - Asserts conv_load_input_buf_fin for exactly 1 cycle: the cycle after the last en_wr, or the cycle after start when count = 0.
  - Then returns to IDLE.
- Counters and outputs:
  - words_written increments on each write cycle, including suppressed writes; saturates at 2^CNT_W-1.
  - Outputs are zero when en_wr=0 (idx/adr/data forced to 0).
  - conv_load_input outside IDLE is ignored.
  - Start and a stray beat in the same cycle in IDLE: the start wins and the beat is treated as RUN (accepted if FIFO non-empty).

Decomposition:
- Shared package conv_accel_pkg holds:
  - INFO_IDX_LSB=16, INFO_ADR_LSB=0, INFO_FIELD_W=16.
  - FSM state encoding (IDLE=0, RUN=1, FLUSH=2).
  - WORD_W, BUFFERS_NUM defaults.
- One natural sub-module, conv_input_info_decode: combinational split and range check of the FIFO entry into idx, adr and bad flag.

Test Plan:
- Basic load:
  - Stimulus: expected=4; beats 1..4 with valid toggling 1,0,1,0; FIFO holds {0,0},{1,0},{2,0},{0,1}.
  - Required: 4 writes, each 1 cycle after its accept, idx 0,1,2,0 / adr 0,0,0,1, data 1..4; fin 1 cycle after the 4th write; words_written=4.
- Back-to-back:
  - Stimulus: expected=8; valid held high; FIFO pre-filled with 8 entries.
  - Required: 8 consecutive en_wr cycles, 8 pops, fin on cycle 10 after first accept.
- Underflow:
  - Stimulus: expected=2; beat with FIFO empty, then 2 beats with FIFO non-empty.
  - Required: first beat dropped, err_underflow=1, exactly 2 writes, fin asserted.
- Bad info:
  - Stimulus: entry idx=3 (BUFFERS_NUM=3), then entry adr=0x1000.
  - Required: no en_wr for either, err_info=1, words_written=2, fin asserted.
- Zero length and stray:
  - Stimulus: expected=0 start; then a beat while in IDLE.
  - Required: fin 1 cycle after start, no pop; err_stray=1, no write.
- Reset mid-load:
  - Stimulus: reset low during RUN with a write pending.
  - Required: en_wr drops immediately, all outputs 0, no fin; next start behaves as fresh.
